gamepad_reader: RTL and testbench
=================================

# gamepad_reader

Serial game-controller front end that produces the per-button levels consumed by the player logic: A, B, select, start, up, down, left, right. It periodically drives the controller's latch and clock lines, shifts in 8 active-low button bits over a synchronized data line, and publishes them atomically as active-high registered levels once per frame. It sits between the pad pins and the player/game-state logic.

## Interface
- HALF_CYCLES, 150: clk cycles per latch/clock half-phase, about 6 µs at 25 MHz; must be at least 4.
- POLL_CYCLES, 420000: clk cycles spent idle between frames, about 60 Hz.
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- pad_data  input  1  serial data from the controller, active-low, asynchronous to clk.
- pad_latch  output  1  parallel-load strobe to the controller, registered.
- pad_clk  output  1  shift clock to the controller, registered.
- A, B, select, start, up, down, left, right  output  1 each  button pressed, active-high, registered.
- frame_valid  output  1  one-cycle pulse when the button outputs update.
- press  output  8  per-button press pulses; present only with GAMEPAD_PRESS_EN.

## Operation
- pad_data passes through a 2-flop synchronizer before use.
- The state machine has four states: IDLE, LATCH, SHIFT and DONE.
- IDLE
  - Counts POLL_CYCLES cycles, then enters LATCH.
  - Reset preloads the counter, so LATCH is entered on the first edge after reset deasserts.
- LATCH
  - pad_latch=1 for 2·HALF_CYCLES cycles, with pad_clk=0.
  - Then enter SHIFT with bit index 0.
- SHIFT: for bit i = 0..7:
  - Low phase: HALF_CYCLES cycles with pad_clk=0. On the last cycle of the low phase, capture the synchronized data into shift[i].
  - High phase, only for i<7: HALF_CYCLES cycles with pad_clk=1, then i increments.
  - After bit 7 is captured, go to DONE. This gives exactly 7 pad_clk pulses per frame.
- Bit order: 0=A, 1=B, 2=select, 3=start, 4=up, 5=down, 6=left, 7=right.
- DONE (one cycle)
  - All 8 button outputs load ~shift in the same cycle; they are never partially updated.
  - frame_valid=1 for that single cycle.
  - The IDLE counter clears and the block returns to IDLE.
- Button outputs hold their values between frames; mid-frame pad_data activity is invisible at the outputs.
- Unplugged controller: pad_data reads high (pull-up), so all buttons report 0.
- No direction masking is applied; simultaneous opposing directions pass through unchanged.

## Timing
- Reset values: pad_latch=0, pad_clk=0, all buttons 0, frame_valid=0, press=0, state IDLE with the counter preloaded.
- Frame length from LATCH entry to DONE is 17·HALF_CYCLES + 1 cycles.
- Frame period is POLL_CYCLES + 17·HALF_CYCLES + 1 cycles.
- Sampling point: the last cycle of each low phase, at least HALF_CYCLES−2 cycles after the preceding pad_clk rise. This covers synchronizer latency.
- Reset mid-frame
  - On the reset edge, pad_latch and pad_clk go 0 and all outputs clear.
  - The partial shift value is discarded and no frame_valid is issued.
- Counter widths are $clog2 of the parameter; all counter compares are equality against parameter−1.

## Configuration
- GAMEPAD_PRESS_EN
  - Defined: the `press` port exists and a previous-frame register is kept.
  - At DONE, press[i] = new[i] & ~old[i], asserted for exactly the frame_valid cycle; otherwise press=0.
  - After reset the previous frame counts as all released.
- Undefined: no `press` port and no previous-frame register.

## Structure
- gamepad_pkg holds:
  - the state enum (IDLE, LATCH, SHIFT, DONE);
  - the button index constants BTN_A=0 … BTN_RIGHT=7;
  - the number of bits, NBITS=8.
- Sub-module pad_sync is the 2-flop synchronizer with a reset value of 1 (released).
- The top level contains the FSM, the phase counter, the bit index, the shift register and the output registers.

## Test plan
Bench parameters: HALF_CYCLES=4, POLL_CYCLES=20, with a behavioural shift-register controller model.
- Reset released → pad_latch rises on the first edge and stays high 8 cycles; all outputs stay 0 until the first frame_valid.
- Model loads A and right pressed (data low at bits 0 and 7) → exactly 7 pad_clk pulses, each 4 cycles high. At the frame_valid cycle (cycle 69 from LATCH entry), A=1 and right=1, all others 0.
- pad_data held at 1 (unplugged) → frame_valid pulses every 89 cycles with all buttons 0.
- Reset asserted during bit 3, held 2 cycles → pad_latch and pad_clk go 0 on the next edge, outputs are 0, no frame_valid, and a fresh LATCH starts on the first edge after release.
- Model changes to up pressed while in IDLE → outputs unchanged until the next frame_valid, then up=1 from that cycle.
- GAMEPAD_PRESS_EN, up held across two frames → press=8'h10 only on the first frame_valid, 8'h00 on the second; releasing then re-pressing up gives 8'h10 again.

Source files
------------

// File: rtl/gamepad_pkg.sv
// Shared types and constants for the serial gamepad reader.
package gamepad_pkg;

  localparam int unsigned NBITS = 8;
  localparam int unsigned BIT_W = $clog2(NBITS);

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the pad data line; resets to 1 (button released).
module pad_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/gamepad_reader.sv
// Serial gamepad front end: latches the pad, shifts in 8 active-low bits and
// publishes them atomically once per frame. GAMEPAD_PRESS_EN adds press pulses.
module gamepad_reader
  import gamepad_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 150,
  parameter int unsigned POLL_CYCLES = 420000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pad_data,
  output logic             pad_latch,
  output logic             pad_clk,
  output logic             A,
  output logic             B,
  output logic             select,
  output logic             start,
  output logic             up,
  output logic             down,
  output logic             left,
  output logic             right,
  output logic             frame_valid
`ifdef GAMEPAD_PRESS_EN
  ,
  output logic [NBITS-1:0] press
`endif
);

  localparam int unsigned PH_W   = $clog2(2 * HALF_CYCLES);
  localparam int unsigned IDLE_W = $clog2(POLL_CYCLES);

  localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_CYCLES - 1);
  localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(2 * HALF_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(POLL_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(NBITS - 1);

  logic data_s;

  state_e            state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic              hi_q, hi_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [NBITS-1:0]  shift_q, shift_d;
  logic [NBITS-1:0]  btn_q, btn_d;
  logic              latch_q, latch_d;
  logic              pclk_q, pclk_d;
  logic              fv_q, fv_d;
`ifdef GAMEPAD_PRESS_EN
  logic [NBITS-1:0]  press_q, press_d;
`endif

  pad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pad_data),
    .q     (data_s)
  );

  // Pin and button registers are decoded from the next state so they change
  // on the same edge as the state they belong to.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    ph_cnt_d   = ph_cnt_q;
    hi_d       = hi_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    btn_d      = btn_q;

    case (state_q)
      IDLE: begin
        if (idle_cnt_q == IDLE_LAST) begin
          state_d  = LATCH;
          ph_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      LATCH: begin
        if (ph_cnt_q == LATCH_LAST) begin
          state_d  = SHIFT;
          ph_cnt_d = '0;
          hi_d     = 1'b0;
          bit_d    = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      SHIFT: begin
        if (ph_cnt_q == HALF_LAST) begin
          ph_cnt_d = '0;
          if (!hi_q) begin
            // Last cycle of the low phase: sample, then either pulse or finish.
            shift_d[bit_q] = data_s;
            if (bit_q == BIT_LAST) state_d = DONE;
            else                   hi_d    = 1'b1;
          end else begin
            hi_d  = 1'b0;
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      DONE: begin
        state_d    = IDLE;
        idle_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase

    latch_d = (state_d == LATCH);
    pclk_d  = (state_d == SHIFT) && hi_d;
    fv_d    = (state_d == DONE);
    if (fv_d) btn_d = ~shift_d;
`ifdef GAMEPAD_PRESS_EN
    press_d = fv_d ? (btn_d & ~btn_q) : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idle_cnt_q <= IDLE_LAST;
      ph_cnt_q   <= '0;
      hi_q       <= 1'b0;
      bit_q      <= '0;
      shift_q    <= '1;
      btn_q      <= '0;
      latch_q    <= 1'b0;
      pclk_q     <= 1'b0;
      fv_q       <= 1'b0;
`ifdef GAMEPAD_PRESS_EN
      press_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      ph_cnt_q   <= ph_cnt_d;
      hi_q       <= hi_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      btn_q      <= btn_d;
      latch_q    <= latch_d;
      pclk_q     <= pclk_d;
      fv_q       <= fv_d;
`ifdef GAMEPAD_PRESS_EN
      press_q    <= press_d;
`endif
    end
  end

  assign pad_latch   = latch_q;
  assign pad_clk     = pclk_q;
  assign frame_valid = fv_q;
  assign A           = btn_q[BTN_A];
  assign B           = btn_q[BTN_B];
  assign select      = btn_q[BTN_SELECT];
  assign start       = btn_q[BTN_START];
  assign up          = btn_q[BTN_UP];
  assign down        = btn_q[BTN_DOWN];
  assign left        = btn_q[BTN_LEFT];
  assign right       = btn_q[BTN_RIGHT];
`ifdef GAMEPAD_PRESS_EN
  assign press       = press_q;
`endif

endmodule

// File: tb/tb_gamepad_reader.sv
// Directed bench for gamepad_reader with a shift-register pad model;
// press checks are active when GAMEPAD_PRESS_EN is defined.
module tb_gamepad_reader;

  logic clk = 1'b0;
  logic reset;
  logic pad_data;
  logic pad_latch, pad_clk;
  logic A, B, select, start, up, down, left, right;
  logic frame_valid;
  logic [7:0] btn;
`ifdef GAMEPAD_PRESS_EN
  logic [7:0] press;
`endif

  int n_vec = 0;
  int n_err = 0;

  gamepad_reader #(.HALF_CYCLES(4), .POLL_CYCLES(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .pad_data    (pad_data),
    .pad_latch   (pad_latch),
    .pad_clk     (pad_clk),
    .A           (A),
    .B           (B),
    .select      (select),
    .start       (start),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .frame_valid (frame_valid)
`ifdef GAMEPAD_PRESS_EN
    ,
    .press       (press)
`endif
  );

  always #5 clk = ~clk;

  assign btn = {right, left, down, up, start, select, B, A};

  // Controller model: parallel load while latched, shift on each pad_clk rise.
  logic [7:0] pad_val_n = 8'hFF;
  logic [7:0] sr        = 8'hFF;
  logic       pclk_prev = 1'b0;
  always @(posedge clk) begin
    pclk_prev <= pad_clk;
    if (pad_latch)                  sr <= pad_val_n;
    else if (pad_clk && !pclk_prev) sr <= {1'b1, sr[7:1]};
  end
  assign pad_data = sr[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp_btn, input logic [7:0] exp_press);
    check({tag, "_btn"}, 32'(btn), 32'(exp_btn));
`ifdef GAMEPAD_PRESS_EN
    check({tag, "_press"}, 32'(press), 32'(exp_press));
`else
    if (exp_press != exp_press) $display("unreachable");
`endif
  endtask

  // Called at the negedge where pad_latch is first seen high (cycle 1).
  task automatic measure_frame(output int fv_at, output int latch_len, output int pulses,
                               output int hi_min, output int hi_max,
                               output logic [7:0] pre_or, output int overlap);
    int   run;
    logic prev;
    fv_at = 0; latch_len = 0; pulses = 0; hi_min = 1000; hi_max = 0;
    pre_or = '0; overlap = 0; run = 0; prev = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      if (frame_valid) begin
        fv_at = n;
        break;
      end
      pre_or |= btn;
      if (pad_latch) latch_len++;
      if (pad_latch && pad_clk) overlap++;
      if (pad_clk && !prev) pulses++;
      if (pad_clk) run++;
      else if (run > 0) begin
        if (run < hi_min) hi_min = run;
        if (run > hi_max) hi_max = run;
        run = 0;
      end
      prev = pad_clk;
      @(negedge clk);
    end
  endtask

  task automatic wait_fv(input logic [7:0] hold, output int n, output int bad);
    n = 0; bad = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        n = i;
        break;
      end
      if (btn !== hold) bad++;
    end
  endtask

  initial begin
    int fv_at, latch_len, pulses, hi_min, hi_max, overlap, n, bad, rises, fv_seen;
    logic [7:0] pre_or;
    logic prev, found;

    reset     = 1'b1;
    pad_val_n = ~8'h81;
    repeat (3) @(negedge clk);
    check("rst_latch", 32'(pad_latch), 32'd0);
    check("rst_pclk", 32'(pad_clk), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check_frame("rst", 8'h00, 8'h00);

    // A + right, first frame after reset
    reset = 1'b0;
    @(negedge clk);
    check("latch_first_edge", 32'(pad_latch), 32'd1);
    measure_frame(fv_at, latch_len, pulses, hi_min, hi_max, pre_or, overlap);
    check("latch_len", 32'(latch_len), 32'd8);
    check("fv_cycle", 32'(fv_at), 32'd69);
    check("pclk_pulses", 32'(pulses), 32'd7);
    check("pclk_hi_min", 32'(hi_min), 32'd4);
    check("pclk_hi_max", 32'(hi_max), 32'd4);
    check("latch_pclk_overlap", 32'(overlap), 32'd0);
    check("btn_before_fv", 32'(pre_or), 32'd0);
    check_frame("f1", 8'h81, 8'h81);
    @(negedge clk);
    check("fv_one_cycle", 32'(frame_valid), 32'd0);

    // change to up while idle: outputs hold until next frame_valid
    pad_val_n = ~8'h10;
    wait_fv(8'h81, n, bad);
    check("f2_period", 32'(n + 1), 32'd89);
    check("f2_hold", 32'(bad), 32'd0);
    check_frame("f2", 8'h10, 8'h10);

    // unplugged: data stays high
    pad_val_n = 8'hFF;
    wait_fv(8'h10, n, bad);
    check("unplug1_period", 32'(n), 32'd89);
    check_frame("unplug1", 8'h00, 8'h00);
    wait_fv(8'h00, n, bad);
    check("unplug2_period", 32'(n), 32'd89);
    check("unplug2_hold", 32'(bad), 32'd0);
    check_frame("unplug2", 8'h00, 8'h00);

    pad_val_n = ~8'h10;
    wait_fv(8'h00, n, bad);
    check_frame("f_up", 8'h10, 8'h10);

    // reset during bit 3 low phase
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pad_latch) break;
    end
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pad_clk && !prev) rises++;
      if (rises == 3 && !pad_clk) begin
        found = 1'b1;
        break;
      end
      prev = pad_clk;
    end
    check("bit3_reached", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    fv_seen = int'(frame_valid);
    check("mid_rst_latch", 32'(pad_latch), 32'd0);
    check("mid_rst_pclk", 32'(pad_clk), 32'd0);
    check_frame("mid_rst", 8'h00, 8'h00);
    @(negedge clk);
    fv_seen += int'(frame_valid);
    check("mid_rst_no_fv", 32'(fv_seen), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("relatch_first_edge", 32'(pad_latch), 32'd1);
    measure_frame(fv_at, latch_len, pulses, hi_min, hi_max, pre_or, overlap);
    check("rst_frame_fv_cycle", 32'(fv_at), 32'd69);
    check("rst_frame_btn_before", 32'(pre_or), 32'd0);
    check_frame("rst_frame", 8'h10, 8'h10);

    // up held, then released, then pressed again
    wait_fv(8'h10, n, bad);
    check_frame("up_held", 8'h10, 8'h00);
    pad_val_n = 8'hFF;
    wait_fv(8'h10, n, bad);
    check_frame("up_release", 8'h00, 8'h00);
    pad_val_n = ~8'h10;
    wait_fv(8'h00, n, bad);
    check_frame("up_repress", 8'h10, 8'h10);
    @(negedge clk);
    check_frame("after_fv", 8'h10, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
